// File: rtl/waveform_pkg.sv
// Shared types and constants for the waveform sequencer slice.
// Pure declarations; no timing or flow-control behaviour of its own.
package waveform_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        PLAY    = 2'd2
    } state_t;

    localparam logic [3:0] WF_SINE = 4'b0001;
    localparam logic [3:0] WF_TRI  = 4'b0010;
    localparam logic [3:0] WF_SQR  = 4'b0100;
    localparam logic [3:0] WF_FM   = 4'b1000;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/waveform_seq_ctrl_if.sv
// Switch, converter and DAC signals of the waveform sequencer.
// master = sequencer side, slave = switches/converter/DAC side.
interface waveform_seq_ctrl_if;
    logic       enable;
    logic [3:0] sw_in;
    logic [3:0] conv_sw;
    logic       conv_start;
    logic       conv_rdy;
    logic [7:0] rd_idx;
    logic [7:0] rd_data;
    logic [7:0] dac_data;
    logic       dac_strobe;
    logic       busy;
    logic       err;

    modport master (
        input  enable, sw_in, conv_rdy, rd_data,
        output conv_sw, conv_start, rd_idx, dac_data, dac_strobe, busy, err
    );

    modport slave (
        output enable, sw_in, conv_rdy, rd_data,
        input  conv_sw, conv_start, rd_idx, dac_data, dac_strobe, busy, err
    );
endinterface

// File: rtl/sw_debouncer.sv
// Switch debouncer: accept pulses for one cycle once a one-hot value has been held DEBOUNCE cycles.
// Non-one-hot values never produce an accept; no backpressure.
module sw_debouncer
    import waveform_pkg::*;
#(
    parameter int DEBOUNCE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_in,
    output logic [3:0] sw_stable,
    output logic       accept
);

    logic [3:0]  sw_prev;
    logic [15:0] stab_cnt;

    // stab_cnt == k means sw_prev has been sampled k+1 consecutive cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_prev  <= 4'b0000;
            stab_cnt <= 16'd0;
        end else begin
            sw_prev <= sw_in;
            if (sw_in != sw_prev)
                stab_cnt <= 16'd0;
            else if (stab_cnt != 16'hFFFF)
                stab_cnt <= stab_cnt + 16'd1;
        end
    end

    assign sw_stable = sw_prev;
    assign accept    = (stab_cnt == 16'(DEBOUNCE - 1)) && is_onehot4(sw_prev);

endmodule

// File: rtl/waveform_seq_ctrl.sv
// Sequences the waveform converter (start/ready with timeout) and plays its 256-entry table to the DAC.
// One sample every DIV cycles; new selections are applied only after the index-255 sample.
module waveform_seq_ctrl
    import waveform_pkg::*;
#(
    parameter int DIV      = 4,
    parameter int DEBOUNCE = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    waveform_seq_ctrl_if.master bus
);

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    state_t          state;
    logic            enable_d;
    logic            pending;
    logic [3:0]      sel_next;
    logic [3:0]      conv_sw;
    logic            conv_start;
    logic [7:0]      rd_idx;
    logic [7:0]      dac_data;
    logic            dac_strobe;
    logic            err;
    logic [15:0]     div_cnt;
    logic [TO_W-1:0] wait_cnt;

    logic [3:0] sw_stable;
    logic       sw_accept;
    logic       accept_new;
    logic       pend_now;
    logic [3:0] sel_now;
    logic       div_last;
    logic       enter_conv;

    sw_debouncer #(.DEBOUNCE(DEBOUNCE)) u_sw_debouncer (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (bus.sw_in),
        .sw_stable (sw_stable),
        .accept    (sw_accept)
    );

    // An acceptance in the same cycle as a boundary is folded straight into that boundary
    assign accept_new = sw_accept && (sw_stable != conv_sw);
    assign pend_now   = pending || accept_new;
    assign sel_now    = accept_new ? sw_stable : sel_next;
    assign div_last   = (div_cnt == 16'(DIV - 1));
    assign enter_conv = bus.enable &&
                        (((state == IDLE) && !enable_d) ||
                         ((state == PLAY) && div_last && (rd_idx == 8'hFF) && pend_now));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            enable_d   <= 1'b0;
            pending    <= 1'b0;
            sel_next   <= WF_SINE;
            conv_sw    <= WF_SINE;
            conv_start <= 1'b0;
            rd_idx     <= 8'd0;
            dac_data   <= 8'd0;
            dac_strobe <= 1'b0;
            err        <= 1'b0;
            div_cnt    <= 16'd0;
            wait_cnt   <= '0;
        end else begin
            enable_d   <= bus.enable;
            conv_start <= 1'b0;
            dac_strobe <= 1'b0;
            if (accept_new) begin
                pending  <= 1'b1;
                sel_next <= sw_stable;
            end
            if (!bus.enable) begin
                state   <= IDLE;
                rd_idx  <= 8'd0;
                div_cnt <= 16'd0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    CONVERT: begin
                        wait_cnt <= wait_cnt + TO_ONE;
                        // rdy from the previous conversion is still up during the start cycle
                        if (!conv_start && bus.conv_rdy) begin
                            state   <= PLAY;
                            rd_idx  <= 8'd0;
                            div_cnt <= 16'd0;
                        end else if (wait_cnt == TO_LAST) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    PLAY: begin
                        if (div_last) begin
                            div_cnt    <= 16'd0;
                            dac_data   <= bus.rd_data;
                            dac_strobe <= 1'b1;
                            rd_idx     <= rd_idx + 8'd1;
                        end else if (div_cnt != 16'hFFFF) begin
                            div_cnt <= div_cnt + 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (enter_conv) begin
                    state      <= CONVERT;
                    conv_start <= 1'b1;
                    wait_cnt   <= '0;
                    pending    <= 1'b0;
                    err        <= 1'b0;
                    if (pend_now)
                        conv_sw <= sel_now;
                end
            end
        end
    end

    assign bus.conv_sw    = conv_sw;
    assign bus.conv_start = conv_start;
    assign bus.rd_idx     = rd_idx;
    assign bus.dac_data   = dac_data;
    assign bus.dac_strobe = dac_strobe;
    assign bus.busy       = (state != IDLE);
    assign bus.err        = err;

endmodule

// File: tb/tb_waveform_seq_ctrl.sv
// Bench for waveform_seq_ctrl: converter model with ready 3 cycles after start, identity table.
module tb_waveform_seq_ctrl;
    import waveform_pkg::*;

    localparam int DIV      = 4;
    localparam int DEBOUNCE = 16;
    localparam int TIMEOUT  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic model_never = 1'b0;
    int   rdy_cnt = 0;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] exp_q[$];

    waveform_seq_ctrl_if bus();

    waveform_seq_ctrl #(.DIV(DIV), .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.rd_data = bus.rd_idx;

    // Converter: clears its sticky ready on start, raises it in the third cycle after the start cycle
    always @(negedge clk) begin
        if (rst) begin
            bus.conv_rdy = 1'b0;
            rdy_cnt = 0;
        end else if (bus.conv_start) begin
            bus.conv_rdy = 1'b0;
            rdy_cnt = 1;
        end else if (rdy_cnt > 0) begin
            rdy_cnt++;
            if (rdy_cnt == 4) begin
                rdy_cnt = 0;
                if (!model_never) bus.conv_rdy = 1'b1;
            end
        end
    end

    task automatic test_reset();
        bus.enable = 1'b0;
        bus.sw_in  = WF_SINE;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.conv_sw, bus.conv_start, bus.rd_idx, bus.dac_data, bus.dac_strobe, bus.busy, bus.err}
            !== {WF_SINE, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: got %h expected %h",
                     {bus.conv_sw, bus.conv_start, bus.rd_idx, bus.dac_data, bus.dac_strobe, bus.busy, bus.err},
                     {WF_SINE, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if ({bus.busy, bus.conv_start} !== 2'b00) begin
            fails++;
            $display("FAIL reset_idle: busy/start got %b expected 00", {bus.busy, bus.conv_start});
        end
    endtask

    task automatic test_basic_play();
        int starts = 0, got = 0, cyc = 0, start_cyc = 0, last_cyc = 0;
        logic [7:0] e;
        exp_q.delete();
        for (int i = 0; i < 258; i++) exp_q.push_back(8'(i));
        bus.enable = 1'b1;
        while (got < 258 && cyc < 1500) begin
            @(negedge clk);
            cyc++;
            if (bus.conv_start) begin
                starts++;
                start_cyc = cyc;
            end
            if (bus.dac_strobe) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.dac_data !== e) begin
                    fails++;
                    $display("FAIL play_data: got %0d expected %0d", bus.dac_data, e);
                end
                tests++;
                if (bus.rd_idx !== e + 8'd1) begin
                    fails++;
                    $display("FAIL play_rd_idx: got %0d expected %0d", bus.rd_idx, e + 8'd1);
                end
                tests++;
                if (got == 0 && cyc - start_cyc != 8) begin
                    fails++;
                    $display("FAIL first_strobe_delay: got %0d expected 8", cyc - start_cyc);
                end else if (got != 0 && cyc - last_cyc != DIV) begin
                    fails++;
                    $display("FAIL strobe_interval: got %0d expected %0d", cyc - last_cyc, DIV);
                end
                last_cyc = cyc;
                got++;
            end
        end
        tests++;
        if (got != 258) begin
            fails++;
            $display("FAIL play_count: got %0d strobes expected 258", got);
        end
        tests++;
        if (starts != 1) begin
            fails++;
            $display("FAIL play_starts: got %0d expected 1", starts);
        end
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_switch_boundary();
        int starts = 0, got = 0, cyc = 0;
        logic early_sw = 1'b0, hold_bad = 1'b0;
        logic [7:0] e;
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
        bus.enable = 1'b1;
        while (got < 260 && cyc < 1600) begin
            @(negedge clk);
            cyc++;
            if (bus.dac_strobe) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.dac_data !== e) begin
                    fails++;
                    $display("FAIL switch_data: got %0d expected %0d", bus.dac_data, e);
                end
                if (got == 100) bus.sw_in = WF_SQR;
                got++;
            end else if (got == 256 && bus.dac_data !== 8'hFF) begin
                hold_bad = 1'b1;
            end
            if (starts < 2 && !bus.conv_start && bus.conv_sw !== WF_SINE) early_sw = 1'b1;
            if (bus.conv_start) begin
                starts++;
                if (starts == 2) begin
                    tests++;
                    if (bus.conv_sw !== WF_SQR) begin
                        fails++;
                        $display("FAIL switch_conv_sw: got %b expected %b", bus.conv_sw, WF_SQR);
                    end
                    tests++;
                    if (got != 256) begin
                        fails++;
                        $display("FAIL switch_boundary: restart after %0d samples expected 256", got);
                    end
                end
            end
        end
        tests++;
        if (early_sw) begin
            fails++;
            $display("FAIL switch_early: conv_sw changed before boundary, expected %b", WF_SINE);
        end
        tests++;
        if (hold_bad) begin
            fails++;
            $display("FAIL switch_hold: dac_data moved during reconversion, expected 255");
        end
        tests++;
        if (got != 260 || starts != 2) begin
            fails++;
            $display("FAIL switch_count: got %0d strobes %0d starts expected 260 and 2", got, starts);
        end
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_debounce();
        logic [3:0] hold_val[3] = '{WF_SINE, 4'b0110, WF_SINE};
        int         hold_len[3] = '{DEBOUNCE - 1, 100, DEBOUNCE};
        logic [3:0] after_val[3] = '{WF_SQR, 4'b0110, 4'b0110};
        logic [3:0] exp_sw[3] = '{WF_SQR, WF_SQR, WF_SINE};
        logic seen;
        for (int k = 0; k < 3; k++) begin
            bus.sw_in = hold_val[k];
            repeat (hold_len[k]) @(negedge clk);
            bus.sw_in = after_val[k];
            repeat (40) @(negedge clk);
            bus.enable = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 8 && !seen; i++) begin
                @(negedge clk);
                if (bus.conv_start) seen = 1'b1;
            end
            tests++;
            if (!seen) begin
                fails++;
                $display("FAIL debounce_start[%0d]: no conv_start within 8 cycles", k);
            end
            tests++;
            if (bus.conv_sw !== exp_sw[k]) begin
                fails++;
                $display("FAIL debounce_sel[%0d]: got %b expected %b", k, bus.conv_sw, exp_sw[k]);
            end
            bus.enable = 1'b0;
            repeat (3) @(negedge clk);
        end
        bus.sw_in = WF_SINE;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        int starts = 0;
        logic seen = 1'b0;
        model_never = 1'b1;
        bus.enable = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (bus.conv_start) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL timeout_start: no conv_start within 8 cycles");
        end
        repeat (TIMEOUT - 1) @(negedge clk);
        tests++;
        if ({bus.err, bus.busy} !== 2'b01) begin
            fails++;
            $display("FAIL timeout_early: err/busy got %b expected 01", {bus.err, bus.busy});
        end
        @(negedge clk);
        tests++;
        if ({bus.err, bus.busy} !== 2'b10) begin
            fails++;
            $display("FAIL timeout_err: err/busy got %b expected 10", {bus.err, bus.busy});
        end
        repeat (20) begin
            @(negedge clk);
            if (bus.conv_start) starts++;
        end
        tests++;
        if (starts != 0 || bus.err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_retrigger: starts %0d err %b expected 0 and 1", starts, bus.err);
        end
        bus.enable = 1'b0;
        @(negedge clk);
        model_never = 1'b0;
        bus.enable = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.err, bus.conv_start} !== 2'b01) begin
            fails++;
            $display("FAIL timeout_clear: err/start got %b expected 01", {bus.err, bus.conv_start});
        end
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_enable_drop();
        int got = 0, cyc = 0, stray = 0, starts = 0;
        logic [7:0] e;
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
        bus.enable = 1'b1;
        while (got < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.dac_strobe) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.dac_data !== e) begin
                    fails++;
                    $display("FAIL drop_data: got %0d expected %0d", bus.dac_data, e);
                end
                got++;
            end
        end
        tests++;
        if (got != 10) begin
            fails++;
            $display("FAIL drop_count: got %0d strobes expected 10", got);
        end
        // drop enable in the cycle whose edge would otherwise produce the next strobe
        repeat (DIV - 1) @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.dac_strobe, bus.dac_data, bus.busy, bus.rd_idx} !== {1'b0, 8'd9, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL drop_state: strobe/data/busy/idx got %h expected %h",
                     {bus.dac_strobe, bus.dac_data, bus.busy, bus.rd_idx}, {1'b0, 8'd9, 1'b0, 8'd0});
        end
        repeat (10) begin
            @(negedge clk);
            if (bus.dac_strobe || bus.conv_start) stray++;
        end
        tests++;
        if (stray != 0) begin
            fails++;
            $display("FAIL drop_quiet: got %0d strobe/start cycles expected 0", stray);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(8'(i));
        bus.enable = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.conv_start) starts++;
            if (bus.dac_strobe) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.dac_data !== e) begin
                    fails++;
                    $display("FAIL reenable_data: got %0d expected %0d", bus.dac_data, e);
                end
                got++;
            end
        end
        tests++;
        if (got != 3 || starts != 1) begin
            fails++;
            $display("FAIL reenable_count: got %0d strobes %0d starts expected 3 and 1", got, starts);
        end
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int got = 0, cyc = 0, act = 0;
        bus.sw_in = WF_FM;
        repeat (DEBOUNCE + 4) @(negedge clk);
        bus.enable = 1'b1;
        while (got < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.dac_strobe) got++;
        end
        tests++;
        if (bus.conv_sw !== WF_FM || got != 3) begin
            fails++;
            $display("FAIL midrun_setup: conv_sw %b strobes %0d expected %b and 3", bus.conv_sw, got, WF_FM);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.enable = 1'b0;
        #1;
        tests++;
        if ({bus.conv_sw, bus.conv_start, bus.rd_idx, bus.dac_data, bus.dac_strobe, bus.busy, bus.err}
            !== {WF_SINE, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL midrun_reset: got %h expected %h",
                     {bus.conv_sw, bus.conv_start, bus.rd_idx, bus.dac_data, bus.dac_strobe, bus.busy, bus.err},
                     {WF_SINE, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.conv_start || bus.busy) act++;
        end
        tests++;
        if (act != 0) begin
            fails++;
            $display("FAIL midrun_idle: got %0d active cycles expected 0", act);
        end
    endtask

    initial begin
        test_reset();
        test_basic_play();
        test_switch_boundary();
        test_debounce();
        test_timeout();
        test_enable_drop();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/waveform_seq_ctrl.md
Name: waveform_seq_ctrl

Overview:
Controller that sequences the 256-sample waveform converter and plays its output table to the DAC.
- Debounces and validates the waveform-select switches.
- Issues a one-cycle start to the converter and waits for its ready flag, with a timeout.
- Streams the converted table at a fixed sample rate, wrapping continuously.
- A new waveform selection is applied only at a period boundary, so playback never switches mid-cycle.

Parameters:
DIV, 4, clk cycles per output sample (legal range 2..65535)
DEBOUNCE, 16, cycles sw_in must be stable before a change is accepted (legal range 1..65535)
TIMEOUT, 64, cycles to wait for conv_rdy after conv_start before flagging an error

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  level; 1 = run sequencer, 0 = return to IDLE
sw_in  in  4  raw one-hot waveform select (0001 sine, 0010 triangle, 0100 square, 1000 FM)
conv_sw  out  4  validated select driven to converter
conv_start  out  1  one-cycle start pulse to converter
conv_rdy  in  1  converter ready flag (sticky level)
rd_idx  out  8  sample index into converter output table
rd_data  in  8  table sample at rd_idx (combinational from rd_idx)
dac_data  out  8  registered sample to DAC
dac_strobe  out  1  one-cycle pulse, dac_data newly valid
busy  out  1  1 in CONVERT or PLAY
err  out  1  sticky conversion-timeout flag; cleared by rst or enable rising edge

Behaviour:
- Reset values:
  - Outputs: conv_sw=0001, conv_start=0, rd_idx=0, dac_data=0, dac_strobe=0, busy=0, err=0.
  - Internal: state=IDLE, pending=0, all counters 0.
- Debounce:
  - stab_cnt resets whenever sw_in differs from its value in the previous cycle.
  - When sw_in has been stable for DEBOUNCE cycles, is one-hot, and differs from conv_sw: set pending and latch the new value into sel_next.
  - Non-one-hot values (0000, multi-bit) are ignored entirely.
- IDLE:
  - On an enable rising edge (enable=1, previous sample 0): clear err, go to CONVERT.
  - enable held 1 after a timeout does not retrigger.
- CONVERT:
  - Entry cycle: conv_sw <= sel_next if pending, else unchanged; pending cleared; conv_start=1 for exactly one cycle; wait counter cleared.
  - conv_rdy is ignored on the start cycle and sampled from the following cycle on (the converter flag is sticky).
  - conv_rdy=1 → PLAY with rd_idx=0, div_cnt=0.
  - TIMEOUT cycles elapse without rdy → err=1, go to IDLE.
- PLAY:
  - div_cnt counts 0..DIV-1.
  - When div_cnt==DIV-1: dac_data <= rd_data, dac_strobe=1, rd_idx <= rd_idx+1 (mod 256, so 255 wraps to 0).
  - First strobe occurs DIV cycles after entering PLAY.
  - If pending is set when the strobe for index 255 fires → CONVERT on the next cycle; dac_data holds its last value during reconversion.
- enable=0 in any state → IDLE on the next edge:
  - dac_strobe=0; dac_data holds; rd_idx reset to 0; busy=0.
  - pending and conv_sw are retained.
- Simultaneous events:
  - A switch acceptance in the same cycle as the index-255 strobe takes effect at that boundary.
  - An acceptance during CONVERT sets pending for the next period boundary.
  - enable falling takes priority over every other transition.
- Asynchronous rst mid-operation returns all registers to reset values immediately.
- Widths:
  - div_cnt and stab_cnt are 16 bits, saturating at their terminal values.
  - The timeout counter is sized as $clog2(TIMEOUT+1).

Decomposition:
- Package waveform_pkg:
  - state enum state_t {IDLE, CONVERT, PLAY}.
  - One-hot constants WF_SINE=0001, WF_TRI=0010, WF_SQR=0100, WF_FM=1000.
  - Function is_onehot4.
- One sub-module: sw_debouncer (DEBOUNCE parameter; outputs stable value plus a one-cycle accept pulse).

Test Plan:
- Reset: rst pulsed mid-run → all outputs return to reset values in the same cycle; after release with enable=0, state stays IDLE.
- Basic play: DIV=4; enable rises; converter model asserts rdy 3 cycles after start; table[i]=i.
  - Expect exactly one conv_start pulse.
  - Strobes every 4 cycles with dac_data 0,1,2,…,255,0; rd_idx wraps.
- Period-boundary switch: sw_in changes 0001→0100 at sample 100.
  - conv_sw stays 0001 until the index-255 strobe.
  - Then one conv_start pulse with conv_sw=0100, and playback restarts at index 0.
- Debounce/validation:
  - Glitch of DEBOUNCE-1 cycles → no pending, no conv_start.
  - sw_in=0110 held 100 cycles → ignored, conv_sw unchanged.
- Timeout: converter never asserts rdy → err=1 exactly TIMEOUT cycles after the start cycle; state IDLE, busy=0.
  - A new enable rising edge clears err and issues conv_start.
- Enable drop mid-PLAY: dac_strobe stops next cycle and dac_data holds; re-enable → new conversion, playback from index 0.
